// File: rtl/my_mux_4_way_arbiter_pkg.sv
// Shared types for the 4-way mux arbiter and its demux partner.
// Source tags: a=00, b=01, c=10, d=11.
package my_mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_A = 2'b00;
  localparam sel_t SEL_B = 2'b01;
  localparam sel_t SEL_C = 2'b10;
  localparam sel_t SEL_D = 2'b11;

  localparam int unsigned WIDTH_DEF = 16;

  // Output register occupancy.
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Channel that is k steps after s, 2-bit wrap.
  function automatic sel_t sel_step(
    input sel_t       s,
    input logic [1:0] k
  );
    return sel_t'(s + k);
  endfunction

endpackage

// File: rtl/my_mux_4_way_arbiter_if.sv
// Bundle of four source channels and one merged sink channel.
// slave: arbiter view; master: the producers/consumer around it.
interface my_mux_4_way_arbiter_if #(
  parameter int WIDTH = 16
);

  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] c_in;
  logic [WIDTH-1:0] d_in;

  logic a_valid;
  logic b_valid;
  logic c_valid;
  logic d_valid;

  logic a_ready;
  logic b_ready;
  logic c_ready;
  logic d_ready;

  logic [WIDTH-1:0] out;
  logic [1:0]       out_sel;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  a_in, b_in, c_in, d_in,
    input  a_valid, b_valid, c_valid, d_valid,
    output a_ready, b_ready, c_ready, d_ready,
    output out, out_sel, out_valid,
    input  out_ready
  );

  modport master (
    output a_in, b_in, c_in, d_in,
    output a_valid, b_valid, c_valid, d_valid,
    input  a_ready, b_ready, c_ready, d_ready,
    input  out, out_sel, out_valid,
    output out_ready
  );

endinterface

// File: rtl/my_mux_4_way_arbiter_rr.sv
// Combinational 4-way round-robin arbiter.
// Ports: req/last/en in; one-hot gnt, gnt_idx, gnt_any out.
module my_rr_arbiter_4
  import my_mux_pkg::*;
(
  input  logic [3:0] req,
  input  sel_t       last,
  input  logic       en,
  output logic [3:0] gnt,
  output sel_t       gnt_idx,
  output logic       gnt_any
);

  sel_t cand;

  // Search last+1 .. last+4; the final step revisits last itself.
  always_comb begin
    gnt     = '0;
    gnt_idx = last;
    gnt_any = 1'b0;
    cand    = last;
    for (int k = 1; k <= 4; k++) begin
      cand = sel_step(last, k[1:0]);
      if (en && !gnt_any && req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
    if (gnt_any) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/my_mux_4_way_arbiter.sv
// Merges four valid/ready sources onto one registered sink.
// Ports: clk, reset (async high), bus (slave modport).
module my_mux_4_way_arbiter
  import my_mux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  my_mux_4_way_arbiter_if.slave   bus
);

  logic [3:0]       req;
  logic [3:0]       gnt;
  sel_t             gnt_idx;
  logic             gnt_any;
  logic             can_load;
  logic             arb_en;
  logic [WIDTH-1:0] sel_data;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  sel_t             sel_q, sel_d;
  sel_t             last_q, last_d;

  assign req = {bus.d_valid, bus.c_valid,
                bus.b_valid, bus.a_valid};

  // Register is free or being drained now.
  assign can_load = (state_q == ST_EMPTY) | bus.out_ready;

  // No grants while reset is held.
  assign arb_en = can_load & ~reset;

  my_rr_arbiter_4 u_arb (
    .req     (req),
    .last    (last_q),
    .en      (arb_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    sel_data = bus.a_in;
    unique case (gnt_idx)
      SEL_A: sel_data = bus.a_in;
      SEL_B: sel_data = bus.b_in;
      SEL_C: sel_data = bus.c_in;
      SEL_D: sel_data = bus.d_in;
    endcase
  end

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    sel_d   = sel_q;
    last_d  = last_q;
    if (gnt_any) begin
      out_d  = sel_data;
      sel_d  = gnt_idx;
      last_d = gnt_idx;
    end
    unique case (state_q)
      ST_EMPTY: begin
        if (gnt_any) state_d = ST_FULL;
      end
      ST_FULL: begin
        if (!gnt_any && bus.out_ready)
          state_d = ST_EMPTY;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      out_q   <= '0;
      sel_q   <= SEL_A;
      last_q  <= SEL_D;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
    end
  end

  assign bus.a_ready   = gnt[0];
  assign bus.b_ready   = gnt[1];
  assign bus.c_ready   = gnt[2];
  assign bus.d_ready   = gnt[3];
  assign bus.out       = out_q;
  assign bus.out_sel   = sel_q;
  assign bus.out_valid = (state_q == ST_FULL);

endmodule
